// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses and long-press flag per channel.
// Optional auto-repeat of btn_press during a long press is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int MAX_CYCLES = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
`endif

    // Reject parameter sets the counters cannot honour.
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("btn_conditioner: illegal cycle parameters");
    end

    typedef enum logic [1:0] {IDLE, ARM_P, DOWN, ARM_R} state_t;

    logic [N_BTN-1:0] s1_reg;
    logic [N_BTN-1:0] s2_reg;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= btn_raw;
            s2_reg <= s1_reg;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        state_t        state_reg, state_next;
        logic [CW-1:0] dcnt_reg, dcnt_next;
        logic [CW-1:0] hcnt_reg, hcnt_next;
        logic          long_reg, long_next;
        logic          first_reg, first_next;
        logic          release_reg, release_next;
        logic          level_c;
        logic          press_c;
        logic          s2;
`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] rcnt_reg, rcnt_next;
        logic          rep_reg, rep_next;
`endif

        assign s2 = s2_reg[gi];

        always_ff @(posedge sysclk or negedge reset_n) begin
            if (!reset_n) begin
                state_reg   <= IDLE;
                dcnt_reg    <= '0;
                hcnt_reg    <= '0;
                long_reg    <= 1'b0;
                first_reg   <= 1'b0;
                release_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rcnt_reg    <= '0;
                rep_reg     <= 1'b0;
`endif
            end else begin
                state_reg   <= state_next;
                dcnt_reg    <= dcnt_next;
                hcnt_reg    <= hcnt_next;
                long_reg    <= long_next;
                first_reg   <= first_next;
                release_reg <= release_next;
`ifdef BTN_AUTOREPEAT_EN
                rcnt_reg    <= rcnt_next;
                rep_reg     <= rep_next;
`endif
            end
        end

        always_comb begin
            state_next   = state_reg;
            dcnt_next    = dcnt_reg;
            hcnt_next    = hcnt_reg;
            long_next    = long_reg;
            first_next   = 1'b0;
            release_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_next    = '0;
            rep_next     = 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (s2) begin
                        state_next = ARM_P;
                        dcnt_next  = C_ONE;
                    end
                end
                ARM_P: begin
                    if (!s2) begin
                        state_next = IDLE;
                        dcnt_next  = '0;
                    end else if (dcnt_reg == D_LAST) begin
                        state_next = DOWN;
                        dcnt_next  = '0;
                        hcnt_next  = '0;
                        first_next = 1'b1;
                    end else begin
                        dcnt_next = dcnt_reg + C_ONE;
                    end
                end
                DOWN: begin
                    // hcnt saturates at the long-press threshold instead of wrapping
                    if (hcnt_reg == H_LAST) begin
                        long_next = 1'b1;
                    end else begin
                        hcnt_next = hcnt_reg + C_ONE;
                    end
                    if (!s2) begin
                        state_next = ARM_R;
                        dcnt_next  = C_ONE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (long_reg) begin
                        if (rcnt_reg == R_LAST) begin
                            rep_next = 1'b1;
                        end else begin
                            rcnt_next = rcnt_reg + R_ONE;
                        end
                    end
`endif
                end
                ARM_R: begin
                    if (s2) begin
                        state_next = DOWN;
                    end else if (dcnt_reg == D_LAST) begin
                        state_next   = IDLE;
                        dcnt_next    = '0;
                        hcnt_next    = '0;
                        long_next    = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        dcnt_next = dcnt_reg + C_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                    hcnt_next  = '0;
                    long_next  = 1'b0;
                end
            endcase
        end

        always_comb begin
            level_c = (state_reg == DOWN) || (state_reg == ARM_R);
            press_c = first_reg;
`ifdef BTN_AUTOREPEAT_EN
            press_c = first_reg | rep_reg;
`endif
        end

        assign btn_level[gi]   = level_c;
        assign btn_press[gi]   = press_c;
        assign btn_release[gi] = release_reg;
        assign btn_long[gi]    = long_reg;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short cycle parameters (debounce 8, long 64, repeat 16).
module tb_btn_conditioner;

    localparam int N = 2;
    localparam int D = 8;
    localparam int L = 64;
    localparam int R = 16;

    logic         sysclk;
    logic         reset_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int press_cnt[2]  = '{0, 0};
    int rel_cnt[2]    = '{0, 0};
    int lvl_cnt[2]    = '{0, 0};
    int last_press[2] = '{-1, -1};
    int last_rel[2]   = '{-1, -1};
    int both_cnt    = 0;
    int overlap_cnt = 0;
    int long_rise   = -1;
    logic long_prev = 1'b0;
    logic rel_long  = 1'b1;
    logic rel_level = 1'b1;
    int s, q, p0, p1, r0, r1, l1, b0, last_rise, exp_presses, exp_last;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R)
    ) dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; samples outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (btn_press[c]) begin
                press_cnt[c]++;
                last_press[c] = cyc;
            end
            if (btn_release[c]) begin
                rel_cnt[c]++;
                last_rel[c] = cyc;
                if (c == 0) begin
                    rel_long  = btn_long[0];
                    rel_level = btn_level[0];
                end
            end
            if (btn_level[c]) lvl_cnt[c]++;
            if (btn_press[c] && btn_release[c]) overlap_cnt++;
        end
        if (&btn_press) both_cnt++;
        if (btn_long[0] && !long_prev) long_rise = cyc;
        long_prev = btn_long[0];
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = '0;
        ticks(3);
        check("rst_level",   btn_level,   0);
        check("rst_press",   btn_press,   0);
        check("rst_release", btn_release, 0);
        check("rst_long",    btn_long,    0);
        reset_n = 1'b1;
        ticks(3);
        $display("reset: level=%0d press=%0d release=%0d long=%0d", btn_level, btn_press, btn_release, btn_long);

        // Clean press then release on channel 0
        p0 = press_cnt[0];
        btn_raw[0] = 1'b1;
        s = cyc;
        ticks(40);
        check("t1_press_count", press_cnt[0] - p0, 1);
        check("t1_press_time",  last_press[0], s + D + 2);
        check("t1_level",       btn_level[0], 1);
        check("t1_long",        btn_long[0], 0);
        r0 = rel_cnt[0];
        btn_raw[0] = 1'b0;
        s = cyc;
        ticks(20);
        check("t1_release_count", rel_cnt[0] - r0, 1);
        check("t1_release_time",  last_rel[0], s + D + 2);
        check("t1_level_off",     btn_level[0], 0);
        $display("t1 clean press: press@%0d release@%0d", last_press[0], last_rel[0]);

        // Bouncing press: toggles every 3 cycles, then stable high
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        last_rise = -1;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            if (btn_raw[0]) last_rise = cyc;
            ticks(3);
        end
        btn_raw[0] = 1'b1;
        last_rise = cyc;
        ticks(30);
        check("t2_press_count",   press_cnt[0] - p0, 1);
        check("t2_press_time",    last_press[0], last_rise + D + 2);
        check("t2_release_count", rel_cnt[0] - r0, 0);
        btn_raw[0] = 1'b0;
        ticks(20);
        check("t2_final_release", rel_cnt[0] - r0, 1);
        $display("t2 bounce: press@%0d last_rise@%0d", last_press[0], last_rise);

        // Short glitch on channel 1 is rejected
        p1 = press_cnt[1];
        r1 = rel_cnt[1];
        l1 = lvl_cnt[1];
        btn_raw[1] = 1'b1;
        ticks(5);
        btn_raw[1] = 1'b0;
        ticks(20);
        check("t3_press",   press_cnt[1] - p1, 0);
        check("t3_release", rel_cnt[1] - r1, 0);
        check("t3_level",   lvl_cnt[1] - l1, 0);
        $display("t3 glitch: ch1 presses=%0d releases=%0d", press_cnt[1] - p1, rel_cnt[1] - r1);

        // Long hold on channel 0
        p0 = press_cnt[0];
        long_rise = -1;
        btn_raw[0] = 1'b1;
        s = cyc;
        ticks(200);
        check("t4_long_time",  long_rise, s + D + 2 + L);
        check("t4_long_level", btn_long[0], 1);
`ifdef BTN_AUTOREPEAT_EN
        exp_presses = 8;
        exp_last    = s + D + 2 + L + 7 * R;
`else
        exp_presses = 1;
        exp_last    = s + D + 2;
`endif
        check("t4_press_count", press_cnt[0] - p0, exp_presses);
        check("t4_last_press",  last_press[0], exp_last);
        btn_raw[0] = 1'b0;
        s = cyc;
        ticks(20);
        check("t4_release_time",  last_rel[0], s + D + 2);
        check("t4_long_at_rel",   rel_long, 0);
        check("t4_level_at_rel",  rel_level, 0);
        check("t4_long_after",    btn_long[0], 0);
        $display("t4 long hold: long@%0d release@%0d presses=%0d", long_rise, last_rel[0], press_cnt[0] - p0);

        // Reset while held: no release, re-debounced as a new press
        btn_raw[0] = 1'b1;
        ticks(15);
        check("t5_level_before", btn_level[0], 1);
        r0 = rel_cnt[0];
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_outputs_in_reset", {btn_level, btn_press, btn_release, btn_long}, 0);
        end
        reset_n = 1'b1;
        q = cyc;
        ticks(15);
        check("t5_no_release", rel_cnt[0] - r0, 0);
        check("t5_press_time", last_press[0], q + D + 2);
        btn_raw[0] = 1'b0;
        ticks(20);
        $display("t5 reset mid-hold: new press@%0d reset released@%0d", last_press[0], q);

        // Both channels pressed together
        b0 = both_cnt;
        btn_raw = 2'b11;
        s = cyc;
        ticks(15);
        check("t6_both_count", both_cnt - b0, 1);
        check("t6_press0",     last_press[0], s + D + 2);
        check("t6_press1",     last_press[1], s + D + 2);
        btn_raw = 2'b00;
        ticks(20);
        check("t6_no_overlap", overlap_cnt, 0);
        $display("t6 dual press: press0@%0d press1@%0d", last_press[0], last_press[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
